// File: rtl/div32_iter_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding,
// iteration count and iteration-counter width.
package div32_iter_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div32_iter_negate32.sv
// Conditional two's-complement negate: dout = neg ? ~din + 1 : din.
// Same invert-and-increment form the ALU uses for subtraction, so the
// most negative value maps onto itself (modulo 2^WIDTH).
module negate32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Purely combinational select between the input and its negation.
    always_comb begin
        dout = din;
        if (neg) begin
            dout = ~din + WIDTH'(1);
        end
    end

endmodule

// File: rtl/div32_iter.sv
// Multi-cycle signed divider: magnitudes are divided with WIDTH
// non-restoring iterations, then a single fix-up cycle restores the
// remainder and applies the signs. A one-cycle ready pulse follows.
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state_reg;
    div_state_t       state_next;

    logic [WIDTH:0]   r_reg;          // signed partial remainder, one guard bit
    logic [WIDTH-1:0] q_reg;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] b_mag_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sign_q_reg;     // sA ^ sB
    logic             sign_r_reg;     // sA
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             exception_reg;
    logic             rdy_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             divisor_zero;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;

    // Input magnitudes; |-2^(WIDTH-1)| is kept as the unsigned 2^(WIDTH-1).
    negate32 #(.WIDTH(WIDTH)) u_neg_a (
        .din  (data_operandA),
        .neg  (data_operandA[WIDTH-1]),
        .dout (a_mag)
    );

    negate32 #(.WIDTH(WIDTH)) u_neg_b (
        .din  (data_operandB),
        .neg  (data_operandB[WIDTH-1]),
        .dout (b_mag)
    );

    // Output sign fixes applied during the FIX cycle.
    negate32 #(.WIDTH(WIDTH)) u_neg_q (
        .din  (q_reg),
        .neg  (sign_q_reg),
        .dout (q_signed)
    );

    negate32 #(.WIDTH(WIDTH)) u_neg_r (
        .din  (r_fix),
        .neg  (sign_r_reg),
        .dout (r_signed)
    );

    // One non-restoring step: shift {R,Q} left, add or subtract |B| by the
    // sign R had before the shift, and record the new sign as a quotient bit.
    always_comb begin
        divisor_zero = (data_operandB == '0);
        b_ext        = {1'b0, b_mag_reg};
        r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        r_step       = r_reg[WIDTH] ? (r_shift + b_ext) : (r_shift - b_ext);
        q_step       = {q_reg[WIDTH-2:0], ~r_step[WIDTH]};
        // Only the low WIDTH bits survive, so the restore is done at WIDTH.
        r_fix        = r_reg[WIDTH] ? (r_reg[WIDTH-1:0] + b_mag_reg) : r_reg[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a start pulse in any state (re)starts; otherwise walk the sequence.
    always_comb begin
        state_next = state_reg;
        if (ctrl_div) begin
            state_next = divisor_zero ? DONE : RUN;
        end else begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                RUN:     state_next = (cnt_reg == LAST_ITER) ? FIX : RUN;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath, output registers and the ready pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_reg         <= '0;
            q_reg         <= '0;
            b_mag_reg     <= '0;
            cnt_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            exception_reg <= 1'b0;
            rdy_reg       <= 1'b0;
        end else begin
            // A start arriving in DONE abandons that result, so no pulse.
            rdy_reg <= (state_reg == DONE) && !ctrl_div;
            if (ctrl_div) begin
                if (divisor_zero) begin
                    result_reg    <= '0;
                    remainder_reg <= '0;
                    exception_reg <= 1'b1;
                end else begin
                    r_reg      <= '0;
                    q_reg      <= a_mag;
                    b_mag_reg  <= b_mag;
                    cnt_reg    <= '0;
                    sign_q_reg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    sign_r_reg <= data_operandA[WIDTH-1];
                end
            end else begin
                case (state_reg)
                    RUN: begin
                        r_reg   <= r_step;
                        q_reg   <= q_step;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    FIX: begin
                        result_reg    <= q_signed;
                        remainder_reg <= r_signed;
                        exception_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = result_reg;
    assign data_remainder = remainder_reg;
    assign data_exception = exception_reg;
    assign data_resultRDY = rdy_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_div32_iter.sv
// Directed bench for div32_iter: latency, signs, divide-by-zero,
// overflow corner, restart and asynchronous reset.
module tb_div32_iter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    div32_iter #(.WIDTH(32)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_div       (ctrl_div),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Present operands for one rising edge (E0); returns at the falling edge after E0.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_div = 1'b1;
        op_a     = a;
        op_b     = b;
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask

    // Count rising edges after E0 until ready (bounded); busy must hold until then.
    task automatic wait_rdy(output int edges, output logic busy_ok);
        edges   = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                edges = n;
                break;
            end
        end
        $display("div %h / %h -> q=%h r=%h exc=%b edges=%0d",
                 op_a, op_b, data_result, data_remainder, data_exception, edges);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", data_remainder); end
        n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception got %b want 0", data_exception); end
        n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int e; logic bok;
        start_div(32'd100, 32'd7);
        wait_rdy(e, bok);
        n_checks++; if (e !== 34) begin n_fail++; $display("FAIL basic_latency got %0d want 34", e); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy_during got %b want 1", bok); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_rdy got %b want 0", busy); end
        n_checks++; if (data_result !== 32'd14) begin n_fail++; $display("FAIL basic_result got %h want 0000000e", data_result); end
        n_checks++; if (data_remainder !== 32'd2) begin n_fail++; $display("FAIL basic_remainder got %h want 00000002", data_remainder); end
        n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL basic_exception got %b want 0", data_exception); end
        @(negedge clock);
        n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_pulse got %b want 0", data_resultRDY); end
        n_checks++; if (data_result !== 32'd14) begin n_fail++; $display("FAIL basic_result_hold got %h want 0000000e", data_result); end
    endtask

    task automatic test_signs();
        int e; logic bok;
        start_div(32'hFFFF_FF9C, 32'd7);            // -100 / 7
        wait_rdy(e, bok);
        n_checks++; if (e !== 34) begin n_fail++; $display("FAIL neg_dividend_latency got %0d want 34", e); end
        n_checks++; if (data_result !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_dividend_result got %h want fffffff2", data_result); end
        n_checks++; if (data_remainder !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_dividend_remainder got %h want fffffffe", data_remainder); end
        start_div(32'd7, 32'hFFFF_FF9C);            // 7 / -100
        wait_rdy(e, bok);
        n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL neg_divisor_result got %h want 00000000", data_result); end
        n_checks++; if (data_remainder !== 32'd7) begin n_fail++; $display("FAIL neg_divisor_remainder got %h want 00000007", data_remainder); end
    endtask

    task automatic test_div_zero();
        int e; logic bok;
        start_div(32'd12345, 32'd0);
        wait_rdy(e, bok);
        n_checks++; if (e !== 1) begin n_fail++; $display("FAIL divzero_latency got %0d want 1", e); end
        n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL divzero_result got %h want 0", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL divzero_remainder got %h want 0", data_remainder); end
        n_checks++; if (data_exception !== 1'b1) begin n_fail++; $display("FAIL divzero_exception got %b want 1", data_exception); end
        start_div(32'd12345, 32'd5);
        wait_rdy(e, bok);
        n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL after_divzero_exception got %b want 0", data_exception); end
        n_checks++; if (data_result !== 32'd2469) begin n_fail++; $display("FAIL after_divzero_result got %h want 000009a5", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL after_divzero_remainder got %h want 0", data_remainder); end
    endtask

    task automatic test_overflow();
        int e; logic bok;
        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(e, bok);
        n_checks++; if (data_result !== 32'h8000_0000) begin n_fail++; $display("FAIL minint_by_m1_result got %h want 80000000", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL minint_by_m1_remainder got %h want 0", data_remainder); end
        n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL minint_by_m1_exception got %b want 0", data_exception); end
        start_div(32'h8000_0000, 32'd1);
        wait_rdy(e, bok);
        n_checks++; if (data_result !== 32'h8000_0000) begin n_fail++; $display("FAIL minint_by_1_result got %h want 80000000", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL minint_by_1_remainder got %h want 0", data_remainder); end
    endtask

    task automatic test_restart();
        int rdy_cnt = 0;
        int first_n = -1;
        logic [31:0] res = '0;
        logic [31:0] rem = '1;
        start_div(32'd100, 32'd7);
        repeat (9) @(negedge clock);                // edges E1..E9 have passed
        ctrl_div = 1'b1; op_a = 32'd50; op_b = 32'd5;
        @(negedge clock);                           // E10 samples the new operands
        ctrl_div = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (first_n < 0) begin
                    first_n = n;
                    res = data_result;
                    rem = data_remainder;
                end
            end
        end
        $display("restart 50 / 5 -> q=%h r=%h rdy_count=%0d edges=%0d", res, rem, rdy_cnt, first_n);
        n_checks++; if (rdy_cnt !== 1) begin n_fail++; $display("FAIL restart_rdy_count got %0d want 1", rdy_cnt); end
        n_checks++; if (first_n !== 34) begin n_fail++; $display("FAIL restart_latency got %0d want 34", first_n); end
        n_checks++; if (res !== 32'd10) begin n_fail++; $display("FAIL restart_result got %h want 0000000a", res); end
        n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL restart_remainder got %h want 0", rem); end
    endtask

    task automatic test_async_reset();
        int rdy_cnt = 0;
        int e; logic bok;
        start_div(32'd100, 32'd7);
        repeat (19) @(negedge clock);
        #2 resetn = 1'b0;                           // mid clock-low phase, no edge
        #1;
        n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL async_reset_result got %h want 0", data_result); end
        n_checks++; if (data_remainder !== 32'h0) begin n_fail++; $display("FAIL async_reset_remainder got %h want 0", data_remainder); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
        @(negedge clock);
        resetn = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        $display("async reset: rdy pulses in 40 cycles after release = %0d", rdy_cnt);
        n_checks++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL async_reset_no_rdy got %0d want 0", rdy_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_idle got %b want 0", busy); end
        start_div(32'd9, 32'd3);
        wait_rdy(e, bok);
        n_checks++; if (e !== 34) begin n_fail++; $display("FAIL post_reset_latency got %0d want 34", e); end
        n_checks++; if (data_result !== 32'd3) begin n_fail++; $display("FAIL post_reset_result got %h want 00000003", data_result); end
        n_checks++; if (data_remainder !== 32'd0) begin n_fail++; $display("FAIL post_reset_remainder got %h want 0", data_remainder); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
